faux_host_command_layer: RTL and testbench

- Host-side counterpart of the faux drive command layer: the initiator that issues ATA DMA READ/WRITE EXT commands to the device through the transport layer.
- Accepts one request at a time from a test/user port and builds the H2D register FIS fields.
- Sequences the data phase: counts read dwords; sends write bursts on each DMA Activate.
- Waits for the device's D2H status register FIS, then reports completion, status and errors.

---
 rtl/faux_host_command_layer_if.sv | 64 ++++++
 rtl/faux_host_command_layer.sv | 240 ++++++++++++++++++++++++
 tb/tb_faux_host_command_layer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/faux_host_command_layer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | faux_host_command_layer_if                                                 |
// | User command port, transport handshake and device event bundle.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface faux_host_command_layer_if;
    logic        cmd_stb;
    logic        cmd_write;
    logic [47:0] cmd_lba;
    logic [15:0] cmd_sector_count;
    logic        cmd_ready;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    logic [7:0]  cmd_status;
    logic [3:0]  cmd_err_code;
    logic        transport_layer_ready;
    logic        send_h2d_reg_stb;
    logic        send_data_stb;
    logic [23:0] data_size;
    logic        xmit_done;
    logic [7:0]  h2d_command;
    logic        h2d_cmd_bit;
    logic [47:0] h2d_lba;
    logic [15:0] h2d_sector_count;
    logic [7:0]  h2d_device;
    logic [15:0] h2d_features;
    logic        d2h_reg_stb;
    logic [7:0]  d2h_status;
    logic        d2h_dma_act_stb;
    logic        rx_data_stb;
    logic        remote_abort;
    logic        xmit_error;
    logic        read_crc_fail;
    logic [3:0]  hcl_state;

    // master: the host command layer itself; slave: user, transport and device side
    modport master (
        input  cmd_stb, cmd_write, cmd_lba, cmd_sector_count,
        output cmd_ready, cmd_busy, cmd_done, cmd_error, cmd_status, cmd_err_code,
        input  transport_layer_ready,
        output send_h2d_reg_stb, send_data_stb, data_size,
        input  xmit_done,
        output h2d_command, h2d_cmd_bit, h2d_lba, h2d_sector_count, h2d_device, h2d_features,
        input  d2h_reg_stb, d2h_status, d2h_dma_act_stb, rx_data_stb,
        input  remote_abort, xmit_error, read_crc_fail,
        output hcl_state
    );

    modport slave (
        output cmd_stb, cmd_write, cmd_lba, cmd_sector_count,
        input  cmd_ready, cmd_busy, cmd_done, cmd_error, cmd_status, cmd_err_code,
        output transport_layer_ready,
        input  send_h2d_reg_stb, send_data_stb, data_size,
        output xmit_done,
        input  h2d_command, h2d_cmd_bit, h2d_lba, h2d_sector_count, h2d_device, h2d_features,
        output d2h_reg_stb, d2h_status, d2h_dma_act_stb, rx_data_stb,
        output remote_abort, xmit_error, read_crc_fail,
        input  hcl_state
    );
endinterface
`default_nettype wire

// File: rtl/faux_host_command_layer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | faux_host_command_layer                                                    |
// | Host initiator issuing DMA READ/WRITE EXT and sequencing the data phase.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module faux_host_command_layer #(
    parameter int MAX_BURST_DWORDS = 2048,
    parameter int TIMEOUT_CYCLES   = 100000
) (
    input wire clk,
    input wire rst,
    faux_host_command_layer_if.master bus
);

    localparam int              TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]     MAX_BURST = 24'(MAX_BURST_DWORDS);

    localparam logic [3:0] ST_WAIT_SIG  = 4'd0;
    localparam logic [3:0] ST_IDLE      = 4'd1;
    localparam logic [3:0] ST_SEND_CMD  = 4'd2;
    localparam logic [3:0] ST_READ      = 4'd3;
    localparam logic [3:0] ST_WR_ACT    = 4'd4;
    localparam logic [3:0] ST_WR_SEND   = 4'd5;
    localparam logic [3:0] ST_WAIT_STAT = 4'd6;
    localparam logic [3:0] ST_DONE      = 4'd7;

    logic [3:0]       state_q, state_d;
    logic [23:0]      remaining_q, remaining_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             act_pend_q, act_pend_d;
    logic             write_q, write_d;
    logic [3:0]       err_q, err_d;
    logic [7:0]       status_q, status_d;
    logic [23:0]      data_size_q, data_size_d;
    logic [7:0]       command_q, command_d;
    logic             cmd_bit_q, cmd_bit_d;
    logic [47:0]      lba_q, lba_d;
    logic [15:0]      count_q, count_d;
    logic             reg_stb_q, reg_stb_d;
    logic             data_stb_q, data_stb_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             w_active;
    logic             w_progress;
    logic             w_timeout;
    logic             w_tmo_fire;
    logic             w_act;
    logic             w_rx_count;
    logic [23:0]      w_rem_after_rx;
    logic [23:0]      w_burst;
    logic [23:0]      w_total;
    logic             w_xport_err;

    assign w_active       = (state_q >= ST_SEND_CMD) && (state_q <= ST_WAIT_STAT);
    assign w_progress     = bus.rx_data_stb | bus.d2h_reg_stb | bus.d2h_dma_act_stb | bus.xmit_done;
    assign w_timeout      = w_active && !w_progress && (timer_q == TMR_LAST);
    assign w_act          = bus.d2h_dma_act_stb | act_pend_q;
    assign w_rx_count     = bus.rx_data_stb && (remaining_q != 24'd0);
    assign w_rem_after_rx = w_rx_count ? remaining_q - 24'd1 : remaining_q;
    assign w_burst        = (remaining_q < MAX_BURST) ? remaining_q : MAX_BURST;
    assign w_total        = {1'b0, bus.cmd_sector_count, 7'd0};
    assign w_xport_err    = bus.remote_abort | bus.xmit_error | bus.read_crc_fail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_WAIT_SIG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_tmo_fire = 1'b0;
        case (state_q)
            ST_WAIT_SIG:  if (bus.d2h_reg_stb) state_d = ST_IDLE;
            ST_IDLE:      if (bus.cmd_stb && (bus.cmd_sector_count != 16'd0)) state_d = ST_SEND_CMD;
            ST_SEND_CMD:  if (bus.transport_layer_ready) state_d = write_q ? ST_WR_ACT : ST_READ;
            ST_READ: begin
                // a status FIS alongside the final dword still counts as normal completion
                if (bus.d2h_reg_stb)               state_d = ST_DONE;
                else if (w_rem_after_rx == 24'd0)  state_d = ST_WAIT_STAT;
            end
            ST_WR_ACT:    if (w_act && bus.transport_layer_ready) state_d = ST_WR_SEND;
            ST_WR_SEND:   if (bus.xmit_done) state_d = (remaining_q == 24'd0) ? ST_WAIT_STAT : ST_WR_ACT;
            ST_WAIT_STAT: if (bus.d2h_reg_stb) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_WAIT_SIG;
        endcase
        if (w_timeout && (state_d == state_q)) begin
            state_d    = ST_DONE;
            w_tmo_fire = 1'b1;
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        act_pend_d  = act_pend_q;
        write_d     = write_q;
        err_d       = err_q;
        status_d    = status_q;
        data_size_d = data_size_q;
        command_d   = command_q;
        cmd_bit_d   = cmd_bit_q;
        lba_d       = lba_q;
        count_d     = count_q;
        error_d     = error_q;
        reg_stb_d   = 1'b0;
        data_stb_d  = 1'b0;
        done_d      = 1'b0;
        timer_d     = (w_active && !w_progress && (state_d == state_q)) ? timer_q + 1'b1 : '0;

        case (state_q)
            ST_WAIT_SIG: begin
                if (bus.d2h_reg_stb) status_d = bus.d2h_status;
            end
            ST_IDLE: begin
                if (bus.cmd_stb) begin
                    lba_d      = bus.cmd_lba;
                    count_d    = bus.cmd_sector_count;
                    write_d    = bus.cmd_write;
                    command_d  = bus.cmd_write ? 8'h35 : 8'h25;
                    act_pend_d = 1'b0;
                    err_d      = 4'b0000;
                    if (bus.cmd_sector_count == 16'd0) begin
                        err_d   = 4'b1000;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        remaining_d = w_total;
                    end
                end
            end
            ST_SEND_CMD: begin
                if (bus.transport_layer_ready) begin
                    reg_stb_d = 1'b1;
                    cmd_bit_d = 1'b1;
                end
            end
            ST_READ: begin
                remaining_d = w_rem_after_rx;
                if (bus.d2h_reg_stb) begin
                    status_d = bus.d2h_status;
                    err_d[0] = bus.d2h_status[0];
                    if (w_rem_after_rx != 24'd0) err_d[3] = 1'b1;
                end
            end
            ST_WR_ACT: begin
                // an Activate seen while transport is busy waits here for ready
                if (w_act && bus.transport_layer_ready) begin
                    data_size_d = w_burst;
                    data_stb_d  = 1'b1;
                    remaining_d = remaining_q - w_burst;
                    act_pend_d  = 1'b0;
                end else if (bus.d2h_dma_act_stb) begin
                    act_pend_d  = 1'b1;
                end
            end
            ST_WR_SEND: begin
                if (bus.d2h_dma_act_stb) act_pend_d = 1'b1;
            end
            ST_WAIT_STAT: begin
                if (bus.d2h_reg_stb) begin
                    status_d = bus.d2h_status;
                    err_d[0] = bus.d2h_status[0];
                end
            end
            ST_DONE: begin
                cmd_bit_d = 1'b0;
            end
            default: ;
        endcase

        if (w_active && w_xport_err) err_d[1] = 1'b1;
        if (w_tmo_fire)              err_d[2] = 1'b1;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d  = 1'b1;
            error_d = |err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining_q <= '0;
            timer_q     <= '0;
            act_pend_q  <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= '0;
            status_q    <= '0;
            data_size_q <= '0;
            command_q   <= '0;
            cmd_bit_q   <= 1'b0;
            lba_q       <= '0;
            count_q     <= '0;
            reg_stb_q   <= 1'b0;
            data_stb_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            act_pend_q  <= act_pend_d;
            write_q     <= write_d;
            err_q       <= err_d;
            status_q    <= status_d;
            data_size_q <= data_size_d;
            command_q   <= command_d;
            cmd_bit_q   <= cmd_bit_d;
            lba_q       <= lba_d;
            count_q     <= count_d;
            reg_stb_q   <= reg_stb_d;
            data_stb_q  <= data_stb_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.cmd_ready        = (state_q == ST_IDLE);
    assign bus.cmd_busy         = (state_q != ST_IDLE);
    assign bus.cmd_done         = done_q;
    assign bus.cmd_error        = error_q;
    assign bus.cmd_status       = status_q;
    assign bus.cmd_err_code     = err_q;
    assign bus.send_h2d_reg_stb = reg_stb_q;
    assign bus.send_data_stb    = data_stb_q;
    assign bus.data_size        = data_size_q;
    assign bus.h2d_command      = command_q;
    assign bus.h2d_cmd_bit      = cmd_bit_q;
    assign bus.h2d_lba          = lba_q;
    assign bus.h2d_sector_count = count_q;
    assign bus.h2d_device       = 8'h40;
    assign bus.h2d_features     = 16'h0000;
    assign bus.hcl_state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_faux_host_command_layer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_faux_host_command_layer                                                 |
// | Randomized device/transport stand-in with a transaction-level model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_faux_host_command_layer;

    localparam int TMO  = 50;
    localparam int MAXB = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    faux_host_command_layer_if bus ();

    faux_host_command_layer #(
        .MAX_BURST_DWORDS (MAXB),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_status = 8'h00;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // event monitor, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_h2d = 0, n_data = 0, n_done = 0;
    int         cyc_h2d = 0, cyc_done = 0;
    logic [7:0] h2d_cmd_seen, done_status;
    logic [47:0] h2d_lba_seen;
    logic [15:0] h2d_cnt_seen;
    logic       h2d_cbit_seen, done_err;
    logic [3:0] done_code;
    int         burst_q[$];

    always @(negedge clk) begin
        if (bus.send_h2d_reg_stb) begin
            n_h2d++;
            cyc_h2d       = cyc;
            h2d_cmd_seen  = bus.h2d_command;
            h2d_lba_seen  = bus.h2d_lba;
            h2d_cnt_seen  = bus.h2d_sector_count;
            h2d_cbit_seen = bus.h2d_cmd_bit;
        end
        if (bus.send_data_stb) begin
            n_data++;
            burst_q.push_back(int'(bus.data_size));
        end
        if (bus.cmd_done) begin
            n_done++;
            cyc_done    = cyc;
            done_err    = bus.cmd_error;
            done_code   = bus.cmd_err_code;
            done_status = bus.cmd_status;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_status(input logic [7:0] st);
        bus.d2h_status  = st;
        bus.d2h_reg_stb = 1'b1;
        tick();
        bus.d2h_reg_stb = 1'b0;
    endtask

    task automatic signature(input logic [7:0] st);
        send_status(st);
        tick();
        exp_status = st;
        check_val("sig_state", bus.hcl_state, 4'd1);
        check_val("sig_status", bus.cmd_status, st);
        check_val("sig_ready", {bus.cmd_ready, bus.cmd_busy}, 2'b10);
    endtask

    task automatic wait_done(input int dn0, input int budget);
        int t;
        t = 0;
        while (n_done == dn0 && t < budget) begin
            tick();
            t++;
        end
        check_val("wait_done", n_done != dn0, 1'b1);
    endtask

    // mode 0: normal, 1: short read (k dwords, -1 = random), 2: device silent (timeout)
    task automatic run_cmd(input bit wr, input logic [47:0] lba, input logic [15:0] cnt,
                           input int mode, input int k_in, input bit inj, input logic [7:0] st);
        int h0, d0, dn0, nd0, t, total, rem, k, sz, nb;
        bit sim, injected;
        logic [3:0] ecode;
        h0 = n_h2d; dn0 = n_done; nd0 = n_data; injected = 1'b0; nb = 0;
        burst_q.delete();
        t = 0;
        while (!bus.cmd_ready && t < 50) begin tick(); t++; end
        check_val("wait_ready", bus.cmd_ready, 1'b1);
        bus.cmd_write = wr; bus.cmd_lba = lba; bus.cmd_sector_count = cnt; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        bus.cmd_lba = {$urandom, $urandom};
        bus.cmd_sector_count = 16'($urandom);
        total = int'(cnt) * 128;

        if (cnt == 16'd0) begin
            check_val("zero_done", {bus.cmd_done, bus.cmd_error}, 2'b11);
            check_val("zero_code", bus.cmd_err_code, 4'h8);
            check_val("zero_status", bus.cmd_status, exp_status);
            idle(3);
            check_val("zero_no_h2d", n_h2d - h0, 0);
            check_val("zero_one_done", n_done - dn0, 1);
            return;
        end

        if ($urandom_range(0, 1) == 1) begin
            bus.transport_layer_ready = 1'b0;
            idle($urandom_range(1, 4));
            bus.transport_layer_ready = 1'b1;
        end
        t = 0;
        while (n_h2d == h0 && t < 20) begin tick(); t++; end
        check_val("h2d_sent", n_h2d - h0, 1);
        check_val("h2d_command", h2d_cmd_seen, wr ? 8'h35 : 8'h25);
        check_val("h2d_lba", h2d_lba_seen, lba);
        check_val("h2d_count", h2d_cnt_seen, cnt);
        check_val("h2d_cbit", h2d_cbit_seen, 1'b1);
        check_val("h2d_const", {bus.h2d_device, bus.h2d_features}, {8'h40, 16'h0000});

        ecode = 4'h0;
        if (mode == 2) begin
            ecode = 4'h4;
            wait_done(dn0, TMO + 20);
            check_val("tmo_latency", cyc_done - cyc_h2d, TMO);
        end else if (!wr) begin
            k = total;
            if (mode == 1) k = (k_in >= 0) ? k_in : int'($urandom_range(0, total - 1));
            sim = ($urandom_range(0, 1) == 1) && (k > 0);
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                bus.rx_data_stb = 1'b1;
                if (inj && i == k / 2) begin bus.read_crc_fail = 1'b1; injected = 1'b1; end
                if (sim && i == k - 1) begin bus.d2h_status = st; bus.d2h_reg_stb = 1'b1; end
                tick();
                bus.rx_data_stb = 1'b0; bus.read_crc_fail = 1'b0; bus.d2h_reg_stb = 1'b0;
            end
            if (!sim) begin
                idle($urandom_range(0, 3));
                send_status(st);
            end
            ecode = {(k < total), 1'b0, injected, st[0]};
            exp_status = st;
            wait_done(dn0, 10);
        end else begin
            rem = total;
            while (rem > 0) begin
                sz = (rem < MAXB) ? rem : MAXB;
                d0 = n_data;
                bus.d2h_dma_act_stb = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    bus.transport_layer_ready = 1'b0;
                    tick();
                    bus.d2h_dma_act_stb = 1'b0;
                    idle($urandom_range(1, 3));
                    bus.transport_layer_ready = 1'b1;
                end else begin
                    tick();
                    bus.d2h_dma_act_stb = 1'b0;
                end
                t = 0;
                while (n_data == d0 && t < 20) begin tick(); t++; end
                check_val("burst_sent", n_data - d0, 1);
                check_val("burst_size", burst_q.size() > 0 ? burst_q.pop_front() : -1, sz);
                nb++;
                idle($urandom_range(0, 3));
                if (inj && !injected) begin
                    bus.xmit_error = 1'b1; tick(); bus.xmit_error = 1'b0; injected = 1'b1;
                end
                bus.xmit_done = 1'b1; tick(); bus.xmit_done = 1'b0;
                rem -= sz;
            end
            idle($urandom_range(0, 3));
            send_status(st);
            ecode = {1'b0, 1'b0, injected, st[0]};
            exp_status = st;
            wait_done(dn0, 10);
            check_val("burst_count", n_data - nd0, nb);
        end

        check_val("done_code", done_code, ecode);
        check_val("done_error", done_err, ecode != 4'h0);
        check_val("done_status", done_status, exp_status);
        idle(2);
        check_val("one_done", n_done - dn0, 1);
        check_val("code_hold", bus.cmd_err_code, ecode);
        check_val("post_idle", {bus.cmd_ready, bus.h2d_cmd_bit}, 2'b10);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"}, bus.hcl_state, 4'd0);
        check_val({tag, "_stb"}, {bus.send_h2d_reg_stb, bus.send_data_stb, bus.cmd_done, bus.cmd_error}, 4'b0);
        check_val({tag, "_stat"}, {bus.cmd_status, bus.cmd_err_code, bus.data_size}, 36'h0);
        check_val({tag, "_h2d"}, {bus.h2d_command, bus.h2d_cmd_bit, bus.h2d_lba, bus.h2d_sector_count}, 73'h0);
        check_val({tag, "_dev"}, bus.h2d_device, 8'h40);
        check_val({tag, "_rdy"}, {bus.cmd_ready, bus.cmd_busy}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn0, h0, m, c;
        bit w, inj;
        bus.cmd_stb = 1'b0; bus.cmd_write = 1'b0; bus.cmd_lba = '0; bus.cmd_sector_count = '0;
        bus.transport_layer_ready = 1'b1; bus.xmit_done = 1'b0;
        bus.d2h_reg_stb = 1'b0; bus.d2h_status = '0; bus.d2h_dma_act_stb = 1'b0;
        bus.rx_data_stb = 1'b0; bus.remote_abort = 1'b0; bus.xmit_error = 1'b0; bus.read_crc_fail = 1'b0;

        rst = 1'b0;
        idle(3);
        check_reset_values("rst");
        rst = 1'b1;
        idle(TMO + 10);
        check_val("sig_no_timeout", bus.hcl_state, 4'd0);
        signature(8'h50);

        run_cmd(1'b0, 48'h10, 16'd2, 0, -1, 1'b0, 8'h50);
        run_cmd(1'b1, 48'h1234_5678_9ABC, 16'd20, 0, -1, 1'b0, 8'h50);
        run_cmd(1'b1, 48'h77, 16'd0, 0, -1, 1'b0, 8'h50);
        run_cmd(1'b0, 48'h200, 16'd1, 1, 100, 1'b0, 8'h51);
        run_cmd(1'b1, 48'h300, 16'd3, 2, -1, 1'b0, 8'h50);
        run_cmd(1'b0, 48'h400, 16'd2, 2, -1, 1'b0, 8'h50);
        run_cmd(1'b1, 48'h500, 16'd17, 0, -1, 1'b1, 8'h50);
        run_cmd(1'b0, 48'h600, 16'd1, 0, -1, 1'b1, 8'h41);

        // reset in the middle of a read: no completion may follow
        dn0 = n_done; h0 = n_h2d;
        bus.cmd_write = 1'b0; bus.cmd_lba = 48'hABC; bus.cmd_sector_count = 16'd2; bus.cmd_stb = 1'b1;
        tick();
        bus.cmd_stb = 1'b0;
        idle(3);
        check_val("rr_h2d", n_h2d - h0, 1);
        for (int i = 0; i < 40; i++) begin
            bus.rx_data_stb = 1'b1; tick(); bus.rx_data_stb = 1'b0;
        end
        check_val("rr_in_read", bus.hcl_state, 4'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_values("rr");
        idle(TMO + 10);
        check_val("rr_no_done", n_done - dn0, 0);
        check_val("rr_stay_sig", bus.hcl_state, 4'd0);
        exp_status = 8'h00;
        signature(8'h50);

        for (int r = 0; r < 14; r++) begin
            w   = ($urandom_range(0, 1) == 1);
            c   = w ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 8));
            m   = int'($urandom_range(0, 9));
            m   = (m < 6) ? 0 : (m < 8) ? (w ? 0 : 1) : 2;
            inj = (m != 2) && ($urandom_range(0, 3) == 0);
            run_cmd(w, {$urandom, $urandom}, 16'(c), m, -1, inj, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
